// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states, lane-mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lane);
        logic [3:0] m;
        m = '0;
        unique case (sz)
            SZ_B:    m = 4'b0001 << lane;
            SZ_H:    m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enable; combinational read, no reset.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: request/response handshake, byte/half/word lanes, fault reporting.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned half/word accesses fault instead of being force-aligned.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          rw_q;
    logic [31:0]   addr_q, wdata_q;
    size_e         size_q;

    logic          hs, enter_resp;
    logic          cur_rw;
    logic [31:0]   cur_addr, cur_wdata;
    size_e         cur_size;

    logic [1:0]    lane;
    logic          mis, oob, acc_err;
    logic [3:0]    be;
    logic [31:0]   lane_wdata, mem_rdata, rd_shift, rd_mask, rd_data;

    assign req_ready = nreset && (state == ST_IDLE);
    assign hs        = req_valid && req_ready;

    // With zero wait states the access completes on the handshake edge, so the
    // live request inputs feed the datapath while idle; otherwise the captured copy.
    assign cur_rw    = (state == ST_IDLE) ? req_rw            : rw_q;
    assign cur_addr  = (state == ST_IDLE) ? req_addr          : addr_q;
    assign cur_size  = (state == ST_IDLE) ? size_e'(req_size) : size_q;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata         : wdata_q;

    always_comb begin
        lane = cur_addr[1:0];
        mis  = 1'b0;
        unique case (cur_size)
            SZ_H: begin
`ifdef DMEM_MISALIGN_CHECK_EN
                mis = cur_addr[0];
`else
                lane[0] = 1'b0;
`endif
            end
            SZ_W: begin
`ifdef DMEM_MISALIGN_CHECK_EN
                mis = (cur_addr[1:0] != 2'b00);
`else
                lane = 2'b00;
`endif
            end
            default: ;
        endcase
    end

    assign oob     = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
    assign acc_err = oob || mis || (cur_size == SZ_RSV);

    always_comb begin
        lane_wdata = cur_wdata;
        rd_mask    = '1;
        unique case (cur_size)
            SZ_B: begin
                lane_wdata = {4{cur_wdata[7:0]}};
                rd_mask    = 32'h0000_00FF;
            end
            SZ_H: begin
                lane_wdata = {2{cur_wdata[15:0]}};
                rd_mask    = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign be       = (enter_resp && cur_rw && !acc_err) ? lane_mask(cur_size, lane) : '0;
    assign rd_shift = mem_rdata >> {lane, 3'b000};
    assign rd_data  = rd_shift & rd_mask;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (lane_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hs) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= SZ_B;
            wdata_q <= '0;
        end else if (hs) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            size_q  <= size_e'(req_size);
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (acc_err || cur_rw) ? '0 : rd_data;
            rsp_err   <= acc_err;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 second instance).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        nreset;

    logic        req_valid, req_ready, req_rw, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;

    logic        z_req_valid, z_req_ready, z_req_rw, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [1:0]  z_req_size;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .nreset(nreset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_rw(z_req_rw),
        .req_addr(z_req_addr), .req_size(z_req_size), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // One complete access on the main instance; lat counts edges from handshake to rsp_valid.
    task automatic access(input logic rw, input logic [31:0] addr, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = sz; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) check("rsp_valid_timeout", {31'b0, rsp_valid}, 32'd1);
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, bp_data;
        logic        er;
        int          lat, n, hs_cnt;

        nreset = 1'b0; rsp_ready = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_size = 2'd2; req_wdata = '0;
        z_req_valid = 1'b0; z_req_rw = 1'b0; z_req_addr = '0; z_req_size = 2'd2; z_req_wdata = '0;
        z_rsp_ready = 1'b1;
        #3;
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        @(posedge clk); #1; @(posedge clk); #1;
        nreset = 1'b1; #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        access(1'b1, 32'h0, 2'd2, 32'hCAFE_F00D, rd, er, lat);
        check("sw0_err", {31'b0, er}, 32'd0);
        access(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, rd, er, lat);
        check("sw10_lat",   32'(lat), 32'd3);
        check("sw10_rdata", rd, 32'd0);
        check("sw10_err",   {31'b0, er}, 32'd0);
        check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("post_rsp_ready", {31'b0, req_ready}, 32'd1);
        access(1'b0, 32'h10, 2'd2, 32'h0, rd, er, lat);
        check("lw10_data", rd, 32'hDEAD_BEEF);
        check("lw10_err",  {31'b0, er}, 32'd0);
        check("lw10_lat",  32'(lat), 32'd3);

        access(1'b1, 32'h11, 2'd0, 32'h0000_00AA, rd, er, lat);
        access(1'b0, 32'h10, 2'd2, 32'h0, rd, er, lat);
        check("sb11_lw10", rd, 32'hDEAD_AAEF);
        access(1'b0, 32'h13, 2'd0, 32'h0, rd, er, lat);
        check("lb13", rd, 32'h0000_00DE);
        access(1'b0, 32'h12, 2'd1, 32'h0, rd, er, lat);
        check("lh12", rd, 32'h0000_DEAD);
        access(1'b0, 32'h11, 2'd0, 32'h0, rd, er, lat);
        check("lb11", rd, 32'h0000_00AA);

        access(1'b1, 32'h24, 2'd2, 32'h0123_4567, rd, er, lat);
        access(1'b1, 32'h26, 2'd1, 32'hFFFF_ABCD, rd, er, lat);
        access(1'b0, 32'h24, 2'd2, 32'h0, rd, er, lat);
        check("sh26_lw24", rd, 32'hABCD_4567);
        access(1'b0, 32'h26, 2'd1, 32'h0, rd, er, lat);
        check("lh26", rd, 32'h0000_ABCD);

        // Backpressure: response held while a second request waits unaccepted.
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h10; req_size = 2'd2;
        @(posedge clk); #1;
        req_addr = 32'h13; req_size = 2'd0; req_rw = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_first_data", rsp_rdata, 32'hDEAD_AAEF);
        bp_data = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
            check("bp_data_hold",  rsp_rdata, bp_data);
            check("bp_req_ready",  {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_release_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check("bp_second_lat",  32'(lat), 32'd3);
        check("bp_second_data", rsp_rdata, 32'h0000_00DE);
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;

        // Faults
        access(1'b1, 32'h1000, 2'd2, 32'h1234_5678, rd, er, lat);
        check("oob_sw_err",   {31'b0, er}, 32'd1);
        check("oob_sw_rdata", rd, 32'd0);
        access(1'b0, 32'h0, 2'd2, 32'h0, rd, er, lat);
        check("oob_no_alias", rd, 32'hCAFE_F00D);
        access(1'b0, 32'h10, 2'd3, 32'h0, rd, er, lat);
        check("rsv_lw_err",   {31'b0, er}, 32'd1);
        check("rsv_lw_rdata", rd, 32'd0);
        access(1'b1, 32'h10, 2'd3, 32'h0, rd, er, lat);
        check("rsv_sw_err", {31'b0, er}, 32'd1);
        access(1'b0, 32'h10, 2'd2, 32'h0, rd, er, lat);
        check("rsv_no_write", rd, 32'hDEAD_AAEF);
        access(1'b0, 32'hFFC, 2'd2, 32'h0, rd, er, lat);
        check("last_word_err", {31'b0, er}, 32'd0);
        access(1'b0, 32'hFFFF_FFFC, 2'd2, 32'h0, rd, er, lat);
        check("top_addr_err", {31'b0, er}, 32'd1);
        access(1'b0, 32'h12, 2'd2, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_lw_err",   {31'b0, er}, 32'd1);
        check("mis_lw_rdata", rd, 32'd0);
`else
        check("mis_lw_err",   {31'b0, er}, 32'd0);
        check("mis_lw_rdata", rd, 32'hDEAD_AAEF);
`endif

        // Reset during WAIT aborts the write.
        access(1'b1, 32'h20, 2'd2, 32'h7654_3210, rd, er, lat);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        nreset = 1'b0; #1;
        check("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_rdata", rsp_rdata, 32'd0);
        check("mid_rst_err",   {31'b0, rsp_err}, 32'd0);
        @(posedge clk); #1; @(posedge clk); #1;
        nreset = 1'b1; #1;
        check("mid_rst_release_ready", {31'b0, req_ready}, 32'd1);
        access(1'b0, 32'h20, 2'd2, 32'h0, rd, er, lat);
        check("mid_rst_no_write", rd, 32'h7654_3210);

        // Zero wait states, rsp_ready tied high.
        z_req_valid = 1'b1; z_req_rw = 1'b1; z_req_addr = 32'h4; z_req_size = 2'd2; z_req_wdata = 32'h0BAD_CAFE;
        n = 0;
        while (!z_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        check("w0_valid_next", {31'b0, z_rsp_valid}, 32'd1);
        check("w0_wr_rdata",   z_rsp_rdata, 32'd0);
        check("w0_busy",       {31'b0, z_req_ready}, 32'd0);
        z_req_rw = 1'b0;
        @(posedge clk); #1;
        check("w0_idle_valid", {31'b0, z_rsp_valid}, 32'd0);
        check("w0_idle_ready", {31'b0, z_req_ready}, 32'd1);
        hs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (z_req_valid && z_req_ready) hs_cnt++;
            @(posedge clk); #1;
            if (z_rsp_valid) check("w0_rd_data", z_rsp_rdata, 32'h0BAD_CAFE);
        end
        check("w0_throughput", 32'(hs_cnt), 32'd4);
        z_req_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
